pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the five-stage MIPS core. It generalises the fixed F/D latch to any stage boundary (F/D, D/E, E/M, M/W) with configurable PC, instruction and sideband widths. It adds a valid bit, flush-to-bubble and a new-data strobe, plus optional saturating stall and bubble performance counters. One instance sits between each pair of adjacent stages; the hazard unit drives its stall and flush inputs.

---
 rtl/pipe_stage_reg.sv | 114 +++++++++++
 tb/tb_pipe_stage_reg.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with valid, flush-to-bubble and new-data strobe
// Optional saturating stall/bubble counters enabled by defining PIPE_PERF_CNT_EN.
module pipe_stage_reg #(
    parameter int          PC_W     = 32,
    parameter int          INSTR_W  = 32,
    parameter int          SIDE_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [SIDE_W-1:0]  in_side,
    output logic               out_valid,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [SIDE_W-1:0]  out_side,
    output logic               out_new,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
);

    localparam logic [PC_W-1:0] RESET_PC_T = PC_W'(RESET_PC);

    logic               valid_q, valid_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [SIDE_W-1:0]  side_q, side_d;
    logic               new_q, new_d;

    // Bubble: flush, or a load of an invalid word; bubbles never carry a live opcode.
    logic load_bubble;
    assign load_bubble = flush || (!stall && !in_valid);

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        side_d  = side_q;
        new_d   = 1'b0;
        if (flush || !stall) begin
            pc_d    = in_pc;
            valid_d = !load_bubble;
            new_d   = !load_bubble;
            instr_d = load_bubble ? '0 : in_instr;
            side_d  = load_bubble ? '0 : in_side;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            pc_q    <= RESET_PC_T;
            instr_q <= '0;
            side_q  <= '0;
            new_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            side_q  <= side_d;
            new_q   <= new_d;
        end
    end

    assign out_valid = valid_q;
    assign out_pc    = pc_q;
    assign out_instr = instr_q;
    assign out_side  = side_q;
    assign out_new   = new_q;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
        end else begin
            if (stall && !flush && (stall_cnt_q != '1))
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (load_bubble && (bubble_cnt_q != '1))
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign stall_cnt      = '0;
    assign bubble_cnt     = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed and randomized checks of pipe_stage_reg against a behavioural model
module tb_pipe_stage_reg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int SIDE_W  = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               stall, flush, in_valid, cnt_clr;
    logic [PC_W-1:0]    in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic [SIDE_W-1:0]  in_side;
    logic               out_valid, out_new;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic [SIDE_W-1:0]  out_side;
    logic [CNT_W-1:0]   stall_cnt, bubble_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference state
    bit          m_valid, m_new;
    bit [31:0]   m_pc, m_instr;
    bit [7:0]    m_side;
    int          m_stall_n, m_bubble_n;

    pipe_stage_reg #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .SIDE_W(SIDE_W),
        .RESET_PC(32'h0000_3000), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_side(in_side),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_side(out_side),
        .out_new(out_new), .cnt_clr(cnt_clr), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_valid = 0; m_new = 0; m_pc = 32'h3000; m_instr = 0; m_side = 0;
        m_stall_n = 0; m_bubble_n = 0;
    endtask

    // One clock edge worth of architectural behaviour.
    task automatic model_edge();
        bit bubble, stalled;
        bubble  = flush || (!stall && !in_valid);
        stalled = stall && !flush;
        if (!stalled) begin
            m_pc    = in_pc;
            m_valid = !bubble;
            m_instr = bubble ? 32'd0 : in_instr;
            m_side  = bubble ? 8'd0 : in_side;
        end
        m_new = !stalled && !bubble;
        if (cnt_clr) begin
            m_stall_n = 0; m_bubble_n = 0;
        end else begin
            if (stalled) m_stall_n = (m_stall_n < CNT_MAX) ? m_stall_n + 1 : CNT_MAX;
            if (bubble)  m_bubble_n = (m_bubble_n < CNT_MAX) ? m_bubble_n + 1 : CNT_MAX;
        end
    endtask

    function automatic int exp_cnt(input int n);
`ifdef PIPE_PERF_CNT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, out_valid, m_valid);
        chk({tag, ".pc"}, out_pc, m_pc);
        chk({tag, ".instr"}, out_instr, m_instr);
        chk({tag, ".side"}, out_side, m_side);
        chk({tag, ".new"}, out_new, m_new);
        chk({tag, ".stall_cnt"}, stall_cnt, exp_cnt(m_stall_n));
        chk({tag, ".bubble_cnt"}, bubble_cnt, exp_cnt(m_bubble_n));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit s, input bit f, input bit v, input bit [31:0] pc,
                         input bit [31:0] ins, input bit [7:0] sd, input bit clr);
        stall = s; flush = f; in_valid = v; in_pc = pc; in_instr = ins; in_side = sd; cnt_clr = clr;
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        check_all("reset");
        chk("reset.pc_const", out_pc, 32'h3000);

        // Release between edges; first edge is a normal load
        reset = 1'b1;
        drive(0, 0, 1, 32'h3004, 32'h3402_0005, 8'h5A, 0);
        step("load1");
        chk("load1.instr_const", out_instr, 32'h3402_0005);
        chk("load1.new_const", out_new, 1'b1);

        // Load then stall 3 edges while inputs wander
        drive(0, 0, 1, 32'h3008, 32'h0000_000C, 8'h11, 0);
        step("load2");
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, $urandom_range(0, 1), $urandom, $urandom, 8'($urandom), 0);
            step("stall3");
        end
        chk("stall3.instr_const", out_instr, 32'h0000_000C);
        chk("stall3.pc_const", out_pc, 32'h3008);
        chk("stall3.cnt_const", stall_cnt, exp_cnt(3));

        // Flush wins over stall
        drive(1, 1, 1, 32'h3010, 32'hDEAD_BEEF, 8'hFF, 0);
        step("flush_stall");
        chk("flush_stall.pc_const", out_pc, 32'h3010);
        chk("flush_stall.bub_const", bubble_cnt, exp_cnt(1));

        // Invalid load scrubs the opcode
        drive(0, 0, 0, 32'h3014, 32'hFFFF_FFFF, 8'hAA, 0);
        step("invalid_load");
        chk("invalid_load.instr_const", out_instr, 32'h0);

        // Saturation, then clear overriding a concurrent stall
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 1, $urandom, $urandom, 8'($urandom), 0);
            step("sat");
        end
        chk("sat.cnt_const", stall_cnt, exp_cnt(15));
        drive(1, 0, 1, 32'h3020, 32'h1, 8'h1, 1);
        step("clr");
        chk("clr.cnt_const", stall_cnt, 0);

        // Async reset mid-stall, observed before the next edge
        drive(0, 0, 1, 32'h3030, 32'h2402_0001, 8'h33, 0);
        step("pre_rst_load");
        drive(1, 0, 1, 32'h3034, 32'h2402_0002, 8'h44, 0);
        step("pre_rst_stall");
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #2;
        reset = 1'b1;
        drive(0, 0, 1, 32'h3040, 32'h2402_0003, 8'h55, 0);
        step("post_rst_load");

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) < 7,
                  $urandom, $urandom, 8'($urandom), $urandom_range(0, 19) == 0);
            step("random");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
